sequence_player: RTL and testbench

Playback engine for the Simon game: reads the stored colour sequence out of `sequence_rom` through its read port and lights one of four LEDs per step, with fixed on and off times. Sits between the game controller, which starts playback with a step count, and the LED drivers. `sequence_rom` holds the sequence and is written by the sequence generator. This block is the read-side consumer of that memory and never writes it.

---
 rtl/sequence_player.sv | 123 ++++++++++++
 tb/tb_sequence_player.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sequence_player.sv
// Simon sequence playback: fetches colours from a registered-read ROM and lights
// one of four LEDs per step with fixed on and dark times.
module sequence_player #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic [3:0]        led,
    output logic              busy,
    output logic              done
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   len_clamped;
    logic [1:0]        colour;
    logic [CNT_W-1:0]  cnt;
    logic              on_end;
    logic              off_end;
    logic              last_step;
    logic              accept;

    assign accept      = (state == S_IDLE) && start && !abort;
    assign len_clamped = (length > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : length;
    assign on_end      = (cnt == CNT_W'(ON_CYCLES - 1));
    assign off_end     = (cnt == CNT_W'(OFF_CYCLES - 1));
    assign last_step   = ((idx + (ADDR_W+1)'(1)) == len);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first, otherwise a missed
    // branch infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = (length == '0) ? S_DONE : S_FETCH;
            S_FETCH: state_nx = S_LATCH;
            S_LATCH: state_nx = S_ON;
            S_ON:    if (on_end) state_nx = S_OFF;
            S_OFF:   if (off_end) state_nx = last_step ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    // rd_addr only moves on entry to FETCH (or back to 0 on abort), so the
    // ROM sees a stable address through FETCH and LATCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            len     <= '0;
            colour  <= '0;
            cnt     <= '0;
            rd_addr <= '0;
        end else if (abort) begin
            if (state != S_IDLE) rd_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && length != '0) begin
                        len     <= len_clamped;
                        idx     <= '0;
                        rd_addr <= '0;
                    end
                end
                S_LATCH: begin
                    colour <= rd_data;
                    cnt    <= '0;
                end
                S_ON: begin
                    cnt <= on_end ? '0 : cnt + CNT_W'(1);
                end
                S_OFF: begin
                    if (off_end) begin
                        cnt <= '0;
                        if (!last_step) begin
                            idx     <= idx + (ADDR_W+1)'(1);
                            rd_addr <= ADDR_W'(idx + (ADDR_W+1)'(1));
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        led  = 4'b0000;
        busy = (state != S_IDLE);
        done = (state == S_DONE);
        if (state == S_ON) led = 4'b0001 << colour;
    end

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player: DEPTH=4, ON=4, OFF=2 (P=8), with a
// registered-read ROM holding colours 0,1,2,3.
module tb_sequence_player;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] length;
    logic       abort;
    logic [1:0] rd_addr;
    logic [1:0] rd_data;
    logic [3:0] led;
    logic       busy;
    logic       done;

    logic [1:0] rom [4];
    int         n_asserts = 0;
    int         n_fail    = 0;
    int         idle_addr = 0;

    sequence_player #(
        .DEPTH(4), .ADDR_W(2), .ON_CYCLES(4), .OFF_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .length(length), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data), .led(led), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= rom[rd_addr];

    task automatic check(input string tag, input int k, input logic [3:0] got,
                         input logic [3:0] exp);
        n_asserts++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, k, got, exp);
        end
    endtask

    // Issues start with len_in, then checks cycles 1..ncyc against the
    // expected timeline for n clamped steps. abort_k/start_k (0 = none) pulse
    // abort or a second start (length=1) during that cycle.
    task automatic play(input int len_in, input int n, input int ncyc,
                        input int abort_k, input int start_k, input string tag);
        int         done_cyc;
        int         step;
        int         off;
        logic [3:0] e_led;
        logic [3:0] e_addr;
        logic       e_busy;
        logic       e_done;
        @(negedge clk);
        start  = 1'b1;
        length = len_in[2:0];
        done_cyc = 1 + n * 8;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start = 1'b0;
            step  = (k - 1) / 8;
            off   = (k - 1) % 8;
            if (abort_k != 0 && k > abort_k) begin
                e_led = 4'b0000; e_busy = 1'b0; e_done = 1'b0; e_addr = 4'd0;
            end else begin
                e_busy = (k <= done_cyc);
                e_done = (k == done_cyc);
                e_led  = 4'b0000;
                if (n > 0 && k < done_cyc && off >= 2 && off <= 5)
                    e_led = 4'b0001 << step;
                if (n == 0) e_addr = 4'(idle_addr);
                else        e_addr = 4'((step < n) ? step : n - 1);
            end
            check({tag, " led"},     k, led,            e_led);
            check({tag, " busy"},    k, {3'b000, busy}, {3'b000, e_busy});
            check({tag, " done"},    k, {3'b000, done}, {3'b000, e_done});
            check({tag, " rd_addr"}, k, {2'b00, rd_addr}, e_addr);
            start = (k == start_k);
            if (k == start_k) length = 3'd1;
            abort = (k == abort_k);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rom[0] = 2'd0; rom[1] = 2'd1; rom[2] = 2'd2; rom[3] = 2'd3;
        rst = 1'b1; start = 1'b0; abort = 1'b0; length = 3'd0;
        #12;
        check("reset led",     0, led,              4'b0000);
        check("reset busy",    0, {3'b000, busy},   4'b0000);
        check("reset done",    0, {3'b000, done},   4'b0000);
        check("reset rd_addr", 0, {2'b00, rd_addr}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        play(4, 4, 34, 0, 0, "full4");       idle_addr = 3;
        play(0, 0, 4, 0, 0, "len0");
        play(7, 4, 34, 0, 0, "clamp7");      idle_addr = 3;
        play(1, 1, 11, 0, 0, "single");      idle_addr = 0;
        play(4, 4, 16, 12, 0, "abort");      idle_addr = 0;
        play(2, 2, 18, 0, 0, "after_abort"); idle_addr = 1;
        play(4, 4, 34, 0, 5, "ign_start");   idle_addr = 3;

        play(4, 4, 20, 0, 0, "pre_rst");
        #2 rst = 1'b1;
        #1;
        check("async led",     20, led,              4'b0000);
        check("async busy",    20, {3'b000, busy},   4'b0000);
        check("async rd_addr", 20, {2'b00, rd_addr}, 4'b0000);
        @(negedge clk);
        check("held done", 21, {3'b000, done}, 4'b0000);
        rst = 1'b0;
        idle_addr = 0;
        play(1, 1, 11, 0, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
